// File: rtl/multi_channel_ram_reader_pkg.sv
// Shared definitions for the multi-channel line-buffer read front-end.
// Holds the read-during-write mode encodings, the round-tracking state type and the
// helpers that derive the slot count and check parameter legality.
package multi_channel_ram_reader_pkg;

    // Same-address read-during-write behaviour of the storage.
    localparam int unsigned C_RDW_OLD = 0;  // port returns pre-write data
    localparam int unsigned C_RDW_NEW = 1;  // port returns the data being written

    // Round tracking: Idle while vs is low, Fill until the first round has
    // sampled all of its slots, Run once output loads are due every round.
    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun
    } round_state_e;

    // Number of time slots each physical port is shared across.
    function automatic int unsigned calc_slots(input int unsigned num_ch,
                                               input int unsigned num_phy);
        return (num_phy == 0) ? 0 : num_ch / num_phy;
    endfunction

    // Channels must split evenly over the ports with at least two slots per port.
    function automatic bit params_legal(input int unsigned num_ch,
                                        input int unsigned num_phy,
                                        input int unsigned rdw_mode);
        return (num_phy != 0) && ((num_ch % num_phy) == 0) && ((num_ch / num_phy) >= 2) &&
               (rdw_mode <= C_RDW_NEW);
    endfunction

endpackage

// File: rtl/multi_channel_ram_reader_if.sv
// Bus bundle between the coefficient/address generator and the line-buffer reader.
// Carries the write port, frame-active, per-channel requests and flattened read
// addresses towards the reader, and the round/refresh strobes plus flattened read
// data and validity back.
//   master : the generator side (drives write port, vs, req, raddr)
//   slave  : the reader side (drives round_start, rdata, rdata_valid, rd_update)
interface multi_channel_ram_reader_if #(
    parameter int unsigned C_ADDR_WIDTH = 8,
    parameter int unsigned C_DATA_WIDTH = 8,
    parameter int unsigned C_NUM_CH     = 8
) ();

    logic                               wen;
    logic [C_ADDR_WIDTH-1:0]            waddr;
    logic [C_DATA_WIDTH-1:0]            wdata;
    logic                               vs;
    logic [C_NUM_CH-1:0]                req;
    logic [C_NUM_CH*C_ADDR_WIDTH-1:0]   raddr;
    logic                               round_start;
    logic [C_NUM_CH*C_DATA_WIDTH-1:0]   rdata;
    logic [C_NUM_CH-1:0]                rdata_valid;
    logic                               rd_update;

    modport master (
        output wen, waddr, wdata, vs, req, raddr,
        input  round_start, rdata, rdata_valid, rd_update
    );

    modport slave (
        input  wen, waddr, wdata, vs, req, raddr,
        output round_start, rdata, rdata_valid, rd_update
    );

endinterface

// File: rtl/bram_1w_nr.sv
// Line-buffer storage: one write port and C_NUM_PHY synchronous read ports with a
// single cycle of read latency. Same-address read-during-write follows C_RDW_MODE.
//   clk   : clock
//   wen   : write enable
//   waddr : write address
//   wdata : write data
//   raddr : flattened read addresses, port p at [p*AW +: AW]
//   rdata : flattened registered read data, same packing
module bram_1w_nr
    import multi_channel_ram_reader_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 8,
    parameter int unsigned C_DATA_WIDTH = 8,
    parameter int unsigned C_NUM_PHY    = 2,
    parameter int unsigned C_RDW_MODE   = C_RDW_OLD
) (
    input  logic                              clk,
    input  logic                              wen,
    input  logic [C_ADDR_WIDTH-1:0]           waddr,
    input  logic [C_DATA_WIDTH-1:0]           wdata,
    input  logic [C_NUM_PHY*C_ADDR_WIDTH-1:0] raddr,
    output logic [C_NUM_PHY*C_DATA_WIDTH-1:0] rdata
);

    localparam int unsigned AW    = C_ADDR_WIDTH;
    localparam int unsigned DW    = C_DATA_WIDTH;
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads sample mem before this edge's write lands, which gives old-data
    // behaviour for free; new-data mode forwards wdata through the output register.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < C_NUM_PHY; p++) begin
            if ((C_RDW_MODE == C_RDW_NEW) && wen && (waddr == raddr[p*AW +: AW])) begin
                rdata[p*DW +: DW] <= wdata;
            end else begin
                rdata[p*DW +: DW] <= mem[raddr[p*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/multi_channel_ram_reader.sv
// Time-multiplexed read front-end for the bicubic line buffers. C_NUM_CH channels
// share C_NUM_PHY physical read ports by rotating through S = C_NUM_CH/C_NUM_PHY
// slots. At each round start the addresses and requests are snapshotted; port p
// reads channel p*S+k in slot k, results are collected in hold registers and the
// whole set is published S+1 edges after the snapshot, with a one-cycle rd_update.
//   clk : sole clock
//   rst : synchronous active-high reset
//   bus : slave side of multi_channel_ram_reader_if (write port, vs, req, raddr in;
//         round_start, rdata, rdata_valid, rd_update out)
module multi_channel_ram_reader
    import multi_channel_ram_reader_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 8,
    parameter int unsigned C_DATA_WIDTH = 8,
    parameter int unsigned C_NUM_CH     = 8,
    parameter int unsigned C_NUM_PHY    = 2,
    parameter int unsigned C_RDW_MODE   = C_RDW_OLD
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_channel_ram_reader_if.slave bus
);

    localparam int unsigned AW    = C_ADDR_WIDTH;
    localparam int unsigned DW    = C_DATA_WIDTH;
    localparam int unsigned S     = calc_slots(C_NUM_CH, C_NUM_PHY);
    localparam int unsigned CNT_W = (S > 1) ? $clog2(S) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST    = CNT_W'(S - 1);
    localparam logic [CNT_W-1:0] SLOT_PRELAST = CNT_W'(S - 2);

    if (!params_legal(C_NUM_CH, C_NUM_PHY, C_RDW_MODE)) begin : g_param_error
        $error("multi_channel_ram_reader: illegal C_NUM_CH/C_NUM_PHY/C_RDW_MODE");
    end

    round_state_e                state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            rd_slot;
    logic [CNT_W-1:0]            cap_slot;
    logic                        round_start;
    logic                        capture;
    logic                        load;

    logic [AW-1:0]               snap_addr_q [C_NUM_CH];
    logic [C_NUM_CH-1:0]         snap_req_q;
    logic [C_NUM_CH-1:0]         req_pipe_q;
    logic [DW-1:0]               hold_q [C_NUM_CH];
    logic [C_NUM_CH*DW-1:0]      rdata_q;
    logic [C_NUM_CH*DW-1:0]      rdata_load;
    logic [C_NUM_CH-1:0]         rdata_valid_q;
    logic                        rd_update_q;

    logic [C_NUM_PHY*AW-1:0]     ram_raddr;
    logic [C_NUM_PHY*DW-1:0]     ram_rdata;

    bram_1w_nr #(
        .C_ADDR_WIDTH (AW),
        .C_DATA_WIDTH (DW),
        .C_NUM_PHY    (C_NUM_PHY),
        .C_RDW_MODE   (C_RDW_MODE)
    ) u_bram (
        .clk   (clk),
        .wen   (bus.wen),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign round_start = bus.vs && (cnt_q == '0);

    // The slot being sampled this edge lags cnt by one, the slot whose data is
    // on the RAM output lags by two (both modulo S).
    always_comb begin
        rd_slot  = (cnt_q == '0) ? SLOT_LAST : cnt_q - CNT_W'(1);
        cap_slot = cnt_q - CNT_W'(2);
        if (cnt_q == '0) begin
            cap_slot = SLOT_PRELAST;
        end else if (cnt_q == CNT_W'(1)) begin
            cap_slot = SLOT_LAST;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!bus.vs || (cnt_q == SLOT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.vs) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = StFill;
                StFill:  if (cnt_q == '0) state_d = StRun;
                StRun:   state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // Slot S-1 results are still on the RAM output at load time, so they bypass
    // the hold registers.
    assign capture = bus.vs && (state_q != StIdle) && (cap_slot != SLOT_LAST);
    assign load    = bus.vs && (state_q == StRun) && (cnt_q == CNT_W'(1));

    always_comb begin
        ram_raddr = '0;
        for (int unsigned p = 0; p < C_NUM_PHY; p++) begin
            ram_raddr[p*AW +: AW] = snap_addr_q[p*S + 32'(rd_slot)];
        end
    end

    always_comb begin
        rdata_load = '0;
        for (int unsigned c = 0; c < C_NUM_CH; c++) begin
            if ((c % S) == (S - 1)) begin
                rdata_load[c*DW +: DW] = ram_rdata[(c / S)*DW +: DW];
            end else begin
                rdata_load[c*DW +: DW] = hold_q[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            snap_req_q    <= '0;
            req_pipe_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= '0;
            rd_update_q   <= 1'b0;
            for (int unsigned c = 0; c < C_NUM_CH; c++) begin
                snap_addr_q[c] <= '0;
                hold_q[c]      <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            // The next snapshot lands on the same edge the last slot of the
            // previous round samples its address; that read uses the old value.
            // The previous round's requests move aside until its output load.
            if (round_start) begin
                req_pipe_q <= snap_req_q;
                snap_req_q <= bus.req;
                for (int unsigned c = 0; c < C_NUM_CH; c++) begin
                    snap_addr_q[c] <= bus.raddr[c*AW +: AW];
                end
            end
            if (capture) begin
                for (int unsigned p = 0; p < C_NUM_PHY; p++) begin
                    hold_q[p*S + 32'(cap_slot)] <= ram_rdata[p*DW +: DW];
                end
            end
            if (!bus.vs) begin
                rdata_valid_q <= '0;
            end else if (load) begin
                rdata_q       <= rdata_load;
                rdata_valid_q <= req_pipe_q;
            end
            rd_update_q <= load;
        end
    end

    assign bus.round_start = round_start;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rd_update   = rd_update_q;

endmodule

// File: tb/tb_multi_channel_ram_reader.sv
// Bench for multi_channel_ram_reader. Three instances share one stimulus stream:
// a (8 ch / 2 ports, old-data RDW), b (8 ch / 2 ports, new-data RDW) and
// c (6 ch / 3 ports, lower six channels of the stream). A round-based reference
// model predicts every output after every edge.
module tb_multi_channel_ram_reader;
    import multi_channel_ram_reader_pkg::*;

    logic        clk;
    logic        rst;
    logic        wen;
    logic        vs;
    logic [7:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  req;
    logic [63:0] raddr;

    int nvec  = 0;
    int nfail = 0;

    multi_channel_ram_reader_if #(.C_ADDR_WIDTH(8), .C_DATA_WIDTH(8), .C_NUM_CH(8)) ifa ();
    multi_channel_ram_reader_if #(.C_ADDR_WIDTH(8), .C_DATA_WIDTH(8), .C_NUM_CH(8)) ifb ();
    multi_channel_ram_reader_if #(.C_ADDR_WIDTH(8), .C_DATA_WIDTH(8), .C_NUM_CH(6)) ifc ();

    assign ifa.wen = wen;   assign ifa.waddr = waddr; assign ifa.wdata = wdata;
    assign ifa.vs  = vs;    assign ifa.req   = req;   assign ifa.raddr = raddr;
    assign ifb.wen = wen;   assign ifb.waddr = waddr; assign ifb.wdata = wdata;
    assign ifb.vs  = vs;    assign ifb.req   = req;   assign ifb.raddr = raddr;
    assign ifc.wen = wen;   assign ifc.waddr = waddr; assign ifc.wdata = wdata;
    assign ifc.vs  = vs;    assign ifc.req   = req[5:0];
    assign ifc.raddr = raddr[47:0];

    multi_channel_ram_reader #(
        .C_ADDR_WIDTH(8), .C_DATA_WIDTH(8), .C_NUM_CH(8), .C_NUM_PHY(2), .C_RDW_MODE(C_RDW_OLD)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    multi_channel_ram_reader #(
        .C_ADDR_WIDTH(8), .C_DATA_WIDTH(8), .C_NUM_CH(8), .C_NUM_PHY(2), .C_RDW_MODE(C_RDW_NEW)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    multi_channel_ram_reader #(
        .C_ADDR_WIDTH(8), .C_DATA_WIDTH(8), .C_NUM_CH(6), .C_NUM_PHY(3), .C_RDW_MODE(C_RDW_OLD)
    ) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. Index g: 0 = 8ch/2ports (S=4), 1 = 6ch/3ports (S=2).
    // Rounds start every S vs-high edges (run index multiple of S); slot k of a
    // round is read k+1 edges after it starts, results publish S+1 edges after.
    logic [7:0] m_mem   [256];
    int         m_run   [2];
    bit         m_live  [2][2];
    int         m_start [2][2];
    logic [7:0] m_req   [2][2];
    logic [7:0] m_addr  [2][2][8];
    logic [7:0] m_dold  [2][2][8];
    logic [7:0] m_dnew  [2][2][8];
    logic [7:0] e_old   [2][8];
    logic [7:0] e_new   [2][8];
    logic [7:0] e_valid [2];
    bit         e_upd   [2];

    task automatic model_cfg(input int g, input int s, input int phy);
        int k;
        int c;
        int j;
        logic [7:0] a;
        e_upd[g] = 1'b0;
        if (rst || !vs) begin
            for (int r = 0; r < 2; r++) m_live[g][r] = 1'b0;
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    e_old[g][i] = 8'h00;
                    e_new[g][i] = 8'h00;
                end
            end
            e_valid[g] = 8'h00;
            m_run[g]   = 0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (m_live[g][r]) begin
                    k = m_run[g] - m_start[g][r] - 1;
                    if (k >= 0 && k < s) begin
                        for (int p = 0; p < phy; p++) begin
                            c = p * s + k;
                            a = m_addr[g][r][c];
                            m_dold[g][r][c] = m_mem[a];
                            m_dnew[g][r][c] = (wen && waddr == a) ? wdata : m_mem[a];
                        end
                    end
                    if (m_run[g] - m_start[g][r] == s + 1) begin
                        for (int i = 0; i < 8; i++) begin
                            e_old[g][i] = m_dold[g][r][i];
                            e_new[g][i] = m_dnew[g][r][i];
                        end
                        e_valid[g]    = m_req[g][r];
                        e_upd[g]      = 1'b1;
                        m_live[g][r]  = 1'b0;
                    end
                end
            end
            if (m_run[g] % s == 0) begin
                j = (m_run[g] / s) % 2;
                m_live[g][j]  = 1'b1;
                m_start[g][j] = m_run[g];
                m_req[g][j]   = req;
                for (int i = 0; i < 8; i++) m_addr[g][j][i] = raddr[i*8 +: 8];
            end
            m_run[g]++;
        end
    endtask

    function automatic logic [63:0] pack_exp(input int g, input bit use_new, input int nch);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < nch; c++) v[c*8 +: 8] = use_new ? e_new[g][c] : e_old[g][c];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        nvec++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic check_all();
        logic rs0;
        logic rs1;
        rs0 = vs && (m_run[0] % 4 == 0);
        rs1 = vs && (m_run[1] % 2 == 0);
        check("a_rdata", ifa.rdata, pack_exp(0, 1'b0, 8));
        check("b_rdata", ifb.rdata, pack_exp(0, 1'b1, 8));
        check("c_rdata", 64'(ifc.rdata), pack_exp(1, 1'b0, 6));
        check("a_valid", 64'(ifa.rdata_valid), 64'(e_valid[0]));
        check("b_valid", 64'(ifb.rdata_valid), 64'(e_valid[0]));
        check("c_valid", 64'(ifc.rdata_valid), 64'(e_valid[1][5:0]));
        check("a_upd", 64'(ifa.rd_update), 64'(e_upd[0]));
        check("b_upd", 64'(ifb.rd_update), 64'(e_upd[0]));
        check("c_upd", 64'(ifc.rd_update), 64'(e_upd[1]));
        check("a_rstart", 64'(ifa.round_start), 64'(rs0));
        check("b_rstart", 64'(ifb.round_start), 64'(rs0));
        check("c_rstart", 64'(ifc.round_start), 64'(rs1));
    endtask

    // One clock edge: model the edge from the inputs it sampled, then compare.
    task automatic step();
        @(posedge clk);
        model_cfg(0, 4, 2);
        model_cfg(1, 2, 3);
        if (wen) m_mem[waddr] = wdata;
        #1;
        check_all();
    endtask

    logic [63:0] want;

    initial begin
        for (int g = 0; g < 2; g++) begin
            m_run[g] = 0;
            for (int r = 0; r < 2; r++) begin
                m_live[g][r] = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    m_dold[g][r][i] = 8'h00;
                    m_dnew[g][r][i] = 8'h00;
                end
            end
        end
        rst = 1'b1; vs = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; req = '0; raddr = '0;
        step();
        step();
        rst = 1'b0;

        // Preload mem[a] = a ^ 5A with the frame idle.
        for (int a = 0; a < 256; a++) begin
            wen = 1'b1; waddr = 8'(a); wdata = 8'(a) ^ 8'h5A;
            step();
        end
        wen = 1'b0;

        // Defaults: all channels requested, channel c reads address c+16.
        for (int c = 0; c < 8; c++) raddr[c*8 +: 8] = 8'(c + 16);
        req = 8'hFF;
        vs  = 1'b1;
        for (int i = 0; i < 6; i++) step();   // E0..E5
        for (int c = 0; c < 8; c++) want[c*8 +: 8] = 8'(c + 16) ^ 8'h5A;
        check("dflt_rdata", ifa.rdata, want);
        check("dflt_valid", 64'(ifa.rdata_valid), 64'hFF);
        check("dflt_upd", 64'(ifa.rd_update), 64'h1);
        check("dflt_c_rdata", 64'(ifc.rdata), want & 64'h0000_FFFF_FFFF_FFFF);
        step();
        check("dflt_upd_off", 64'(ifa.rd_update), 64'h0);
        for (int i = 0; i < 3; i++) step();
        check("dflt_period", 64'(ifa.rd_update), 64'h1);

        // Request masking: data still reflects RAM for masked channels.
        req = 8'hA5;
        for (int i = 0; i < 10; i++) step();
        check("mask_valid", 64'(ifa.rdata_valid), 64'hA5);
        check("mask_rdata", ifa.rdata, want);

        // Read-during-write on channel 0 (address 16) at its slot-0 sampling edge.
        vs = 1'b0;
        wen = 1'b1; waddr = 8'd16; wdata = 8'h4A;
        step();
        wen = 1'b0;
        vs = 1'b1;
        step();                                 // E0
        wen = 1'b1; waddr = 8'd16; wdata = 8'hC3;
        step();                                 // E1
        wen = 1'b0;
        for (int i = 0; i < 4; i++) step();     // E2..E5
        check("rdw_old_mode", 64'(ifa.rdata[7:0]), 64'h4A);
        check("rdw_new_mode", 64'(ifb.rdata[7:0]), 64'hC3);
        for (int i = 0; i < 4; i++) step();     // E6..E9
        check("rdw_next_old", 64'(ifa.rdata[7:0]), 64'hC3);
        check("rdw_next_new", 64'(ifb.rdata[7:0]), 64'hC3);

        // vs falls mid-round, then re-rises.
        for (int i = 0; i < 4 && (m_run[0] % 4) != 2; i++) step();
        vs = 1'b0;
        step();
        check("vsdrop_valid", 64'(ifa.rdata_valid), 64'h0);
        check("vsdrop_rstart", 64'(ifa.round_start), 64'h0);
        step();
        step();
        vs = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Reset mid-round.
        for (int i = 0; i < 2 && (m_run[1] % 2) != 1; i++) step();
        rst = 1'b1;
        vs  = 1'b0;
        step();
        check("rst_c_rdata", 64'(ifc.rdata), 64'h0);
        check("rst_c_valid", 64'(ifc.rdata_valid), 64'h0);
        check("rst_a_rdata", ifa.rdata, 64'h0);
        rst = 1'b0;
        vs  = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Randomised traffic: addresses change every cycle, writes collide often.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 8; c++) raddr[c*8 +: 8] = 8'($urandom_range(0, 31));
            req   = 8'($urandom);
            wen   = ($urandom_range(0, 1) == 1);
            waddr = 8'($urandom_range(0, 31));
            wdata = 8'($urandom);
            vs    = ($urandom_range(0, 15) != 0);
            rst   = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
